soc_nios2_slave_cpu_debug_host: RTL and testbench

SOC_NIOS2_SLAVE_CPU_DEBUG_HOST -- requirements
Module: soc_nios2_slave_cpu_debug_host

---
 rtl/soc_nios2_slave_cpu_debug_host.sv | 145 ++++++++++++++
 tb/tb_soc_nios2_slave_cpu_debug_host.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_nios2_slave_cpu_debug_host.sv
// soc_nios2_slave_cpu_debug_host: runs one virtual-JTAG UIR/CDR/SDR/UDR/RTI pass per command.
// Rev 1.0 - initial release.
`default_nettype none

module soc_nios2_slave_cpu_debug_host #(
  parameter int TCK_HALF = 2,
  parameter int SR_WIDTH = 38
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic [1:0]          rsp_ir_out,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [1:0]          vji_ir_in,
  input  logic                vji_tdo,
  input  logic [1:0]          vji_ir_out
);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RSP} state_t;

  localparam int PERIOD = 2 * TCK_HALF;
  localparam int CW     = 5;
  localparam int BW     = $clog2(SR_WIDTH + 1);

  state_t              state;
  logic [CW-1:0]       phase;
  logic [BW-1:0]       bit_idx;
  logic [SR_WIDTH-1:0] tx_sr;
  logic                period_end;
  logic                tck_rise;

  assign period_end = (phase == CW'(PERIOD - 1));
  // vji_tck rises on the edge that leaves the last low phase; that is also the sample point.
  assign tck_rise   = (phase == CW'(TCK_HALF - 1));
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phase      <= '0;
      bit_idx    <= '0;
      tx_sr      <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ir_out <= '0;
      vji_tck    <= 1'b0;
      vji_tdi    <= 1'b0;
      vji_uir    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_udr    <= 1'b0;
      vji_rti    <= 1'b0;
      vji_ir_in  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= UIR;
            phase     <= '0;
            vji_tck   <= 1'b0;
            vji_uir   <= 1'b1;
            vji_ir_in <= cmd_ir;
            tx_sr     <= cmd_data;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          if (period_end) begin
            phase   <= '0;
            vji_tck <= 1'b0;
            case (state)
              UIR: begin
                state   <= CDR;
                vji_uir <= 1'b0;
                vji_cdr <= 1'b1;
              end
              CDR: begin
                state   <= SDR;
                vji_cdr <= 1'b0;
                vji_sdr <= 1'b1;
                bit_idx <= '0;
                vji_tdi <= tx_sr[0];
                tx_sr   <= tx_sr >> 1;
              end
              SDR: begin
                if (bit_idx == BW'(SR_WIDTH - 1)) begin
                  state   <= UDR;
                  vji_sdr <= 1'b0;
                  vji_udr <= 1'b1;
                  vji_tdi <= 1'b0;
                end else begin
                  bit_idx <= bit_idx + BW'(1);
                  vji_tdi <= tx_sr[0];
                  tx_sr   <= tx_sr >> 1;
                end
              end
              UDR: begin
                state   <= RTI;
                vji_udr <= 1'b0;
                vji_rti <= 1'b1;
              end
              RTI: begin
                state     <= RSP;
                vji_rti   <= 1'b0;
                rsp_valid <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end else begin
            phase <= phase + CW'(1);
            if (tck_rise) begin
              vji_tck <= 1'b1;
              if (state == SDR)
                rsp_data <= {vji_tdo, rsp_data[SR_WIDTH-1:1]};
              if (state == CDR)
                rsp_ir_out <= vji_ir_out;
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_soc_nios2_slave_cpu_debug_host.sv
// Directed bench: a default instance (TCK_HALF=2, SR_WIDTH=38) and a fast one (TCK_HALF=1, SR_WIDTH=8).
// Cycle numbering: the handshake cycle is cycle 0, the first UIR cycle is cycle 1.
`default_nettype none

module tb_soc_nios2_slave_cpu_debug_host;

  localparam int W  = 38;
  localparam int W1 = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, busy;
  logic [1:0]    cmd_ir = '0, rsp_ir_out, vji_ir_in, vji_ir_out = '0;
  logic [W-1:0]  cmd_data = '0, rsp_data;
  logic          vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdo;
  logic          lb_tdo = 1'b0, tdo_force = 1'b0;

  logic          cmd_valid1 = 1'b0, cmd_ready1, rsp_valid1, rsp_ready1 = 1'b0, busy1;
  logic [1:0]    cmd_ir1 = '0, rsp_ir_out1, vji_ir_in1, vji_ir_out1 = 2'b01;
  logic [W1-1:0] cmd_data1 = '0, rsp_data1;
  logic          vji_tck1, vji_tdi1, vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1;
  logic          vji_tdo1 = 1'b1;

  int checks = 0;
  int errors = 0;

  // Loopback slave: tdo repeats tdi one TCK later.
  always @(posedge vji_tck) lb_tdo <= vji_tdi;
  assign vji_tdo = tdo_force ? 1'b1 : lb_tdo;

  soc_nios2_slave_cpu_debug_host #(.TCK_HALF(2), .SR_WIDTH(W)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out),
    .busy(busy), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
    .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti), .vji_ir_in(vji_ir_in),
    .vji_tdo(vji_tdo), .vji_ir_out(vji_ir_out)
  );

  soc_nios2_slave_cpu_debug_host #(.TCK_HALF(1), .SR_WIDTH(W1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir1), .cmd_data(cmd_data1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_ir_out(rsp_ir_out1),
    .busy(busy1), .vji_tck(vji_tck1), .vji_tdi(vji_tdi1), .vji_uir(vji_uir1), .vji_cdr(vji_cdr1),
    .vji_sdr(vji_sdr1), .vji_udr(vji_udr1), .vji_rti(vji_rti1), .vji_ir_in(vji_ir_in1),
    .vji_tdo(vji_tdo1), .vji_ir_out(vji_ir_out1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b expected 1", cmd_ready); end
    checks++; if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_busy_valid got %b expected 00", {busy, rsp_valid}); end
    checks++; if ({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got %b expected 0", {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %h expected 0", rsp_data); end
    checks++; if ({rsp_ir_out, vji_ir_in} !== 4'b0) begin errors++; $display("FAIL reset_ir got %b expected 0", {rsp_ir_out, vji_ir_in}); end
    checks++; if ({cmd_ready1, busy1, vji_tck1} !== 3'b100) begin errors++; $display("FAIL reset_dut1 got %b expected 100", {cmd_ready1, busy1, vji_tck1}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_loopback();
    logic [W-1:0] sent;
    int cyc, sdr_cnt, tck_bad, tdi_bad;
    sent = 38'h2A_5555_5555;
    cmd_ir = 2'b01; cmd_data = sent; vji_ir_out = 2'b11; tdo_force = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cyc = 1; sdr_cnt = 0; tck_bad = 0; tdi_bad = 0;
    checks++; if ({vji_uir, vji_ir_in, vji_tck} !== 4'b1010) begin errors++; $display("FAIL lb_first_uir got %b expected 1010", {vji_uir, vji_ir_in, vji_tck}); end
    while (!rsp_valid && cyc < 400) begin
      if (vji_tck !== (((cyc - 1) % 4) >= 2)) tck_bad++;
      if (vji_sdr) begin
        if (vji_tdi !== sent[sdr_cnt / 4]) tdi_bad++;
        sdr_cnt++;
      end else if (vji_tdi !== 1'b0) tdi_bad++;
      tick();
      cyc++;
    end
    checks++; if (cyc != 169) begin errors++; $display("FAIL lb_rsp_cycle got %0d expected 169", cyc); end
    checks++; if (sdr_cnt != 152) begin errors++; $display("FAIL lb_sdr_cycles got %0d expected 152", sdr_cnt); end
    checks++; if (tck_bad != 0) begin errors++; $display("FAIL lb_tck_shape got %0d bad cycles expected 0", tck_bad); end
    checks++; if (tdi_bad != 0) begin errors++; $display("FAIL lb_tdi got %0d bad cycles expected 0", tdi_bad); end
    checks++; if (rsp_data !== 38'h14_AAAA_AAAA) begin errors++; $display("FAIL lb_rsp_data got %h expected 14aaaaaaaa", rsp_data); end
    checks++; if (rsp_ir_out !== 2'b11) begin errors++; $display("FAIL lb_rsp_ir got %b expected 11", rsp_ir_out); end
    checks++; if ({vji_tck, vji_rti} !== 2'b00) begin errors++; $display("FAIL lb_rsp_strobes got %b expected 00", {vji_tck, vji_rti}); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL lb_rsp_handshake got %b expected 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_tdo_high();
    int cyc;
    tdo_force = 1'b1; vji_ir_out = 2'b10; cmd_ir = 2'b10; cmd_data = 38'h01_2345_6789;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 400) begin tick(); cyc++; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hi_timeout got %b expected 1", rsp_valid); end
    checks++; if (rsp_data !== 38'h3F_FFFF_FFFF) begin errors++; $display("FAIL hi_rsp_data got %h expected 3fffffffff", rsp_data); end
    checks++; if (rsp_ir_out !== 2'b10) begin errors++; $display("FAIL hi_rsp_ir got %b expected 10", rsp_ir_out); end
  endtask

  // Entered with the previous response still pending.
  task automatic test_stall();
    int bad, cyc;
    bad = 0;
    cmd_valid = 1'b1; cmd_ir = 2'b01; cmd_data = '0; rsp_ready = 1'b0;
    repeat (50) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== 38'h3F_FFFF_FFFF || cmd_ready !== 1'b0 ||
          vji_uir !== 1'b0 || vji_ir_in !== 2'b10 || rsp_ir_out !== 2'b10) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles expected 0", bad); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL stall_release got %b expected 01", {rsp_valid, cmd_ready}); end
    tick();
    cmd_valid = 1'b0;
    checks++; if ({vji_uir, vji_ir_in} !== 3'b101) begin errors++; $display("FAIL stall_next_cmd got %b expected 101", {vji_uir, vji_ir_in}); end
    cyc = 1;
    while (!rsp_valid && cyc < 400) begin tick(); cyc++; end
    checks++; if (cyc != 169) begin errors++; $display("FAIL stall_next_rsp got %0d expected 169", cyc); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tdo_force = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc, bad;
    cmd_ir = 2'b11; cmd_data = 38'h15_0F0F_0F0F;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cyc = 1;
    while (!vji_sdr && cyc < 100) begin tick(); cyc++; end
    checks++; if (cyc != 9) begin errors++; $display("FAIL rm_sdr_start got %0d expected 9", cyc); end
    repeat (41) tick();
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 7'b0) begin
      errors++; $display("FAIL rm_strobes got %b expected 0", {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}); end
    checks++; if ({cmd_ready, busy, rsp_valid, vji_ir_in} !== 5'b10000) begin
      errors++; $display("FAIL rm_state got %b expected 10000", {cmd_ready, busy, rsp_valid, vji_ir_in}); end
    tick();
    reset_n = 1'b1;
    bad = 0;
    repeat (200) begin
      tick();
      if (rsp_valid !== 1'b0 || vji_udr !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rm_no_response got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_back_to_back();
    int cyc, uir2, rsp1, rsp2, idle_cnt, ir_bad, tck_bad, st;
    logic prev_uir;
    rsp_ready1 = 1'b1;
    cmd_ir1 = 2'b10; cmd_data1 = 8'h5A; cmd_valid1 = 1'b1;
    tick();
    cmd_ir1 = 2'b01; cmd_data1 = 8'h00;
    cyc = 1; uir2 = 0; rsp1 = 0; rsp2 = 0; idle_cnt = 0; ir_bad = 0; tck_bad = 0; prev_uir = 1'b0;
    while (rsp2 == 0 && cyc < 150) begin
      if (vji_uir1 && !prev_uir && cyc > 1 && uir2 == 0) uir2 = cyc;
      if (uir2 == 0 && vji_ir_in1 !== 2'b10) ir_bad++;
      if (uir2 == cyc && vji_ir_in1 !== 2'b01) ir_bad++;
      if (uir2 == 0 && !busy1) idle_cnt++;
      if (busy1 && !rsp_valid1) begin
        st = (uir2 != 0) ? uir2 : 1;
        if (vji_tck1 !== (((cyc - st) % 2) == 1)) tck_bad++;
      end
      if (rsp_valid1) begin
        if (rsp1 == 0) rsp1 = cyc; else rsp2 = cyc;
        checks++; if ({rsp_data1, rsp_ir_out1} !== 10'h3FD) begin
          errors++; $display("FAIL b2b_rsp_payload got %h expected 3fd", {rsp_data1, rsp_ir_out1}); end
      end
      if (uir2 != 0) cmd_valid1 = 1'b0;
      prev_uir = vji_uir1;
      if (rsp2 == 0) begin tick(); cyc++; end
    end
    rsp_ready1 = 1'b0;
    checks++; if (rsp1 != 25) begin errors++; $display("FAIL b2b_rsp1_cycle got %0d expected 25", rsp1); end
    checks++; if (uir2 != 27) begin errors++; $display("FAIL b2b_uir2_cycle got %0d expected 27", uir2); end
    checks++; if (rsp2 != 51) begin errors++; $display("FAIL b2b_rsp2_cycle got %0d expected 51", rsp2); end
    checks++; if (idle_cnt != 1) begin errors++; $display("FAIL b2b_idle_gap got %0d expected 1", idle_cnt); end
    checks++; if (ir_bad != 0) begin errors++; $display("FAIL b2b_ir_in got %0d bad cycles expected 0", ir_bad); end
    checks++; if (tck_bad != 0) begin errors++; $display("FAIL b2b_tck_shape got %0d bad cycles expected 0", tck_bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback();
    test_tdo_high();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
